// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and width helpers for the store-and-forward AXI4-Stream packet FIFO.
package axis_pkt_fifo_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } state_e;

  // One extra pointer bit tells a full FIFO apart from an empty one.
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  function automatic int entry_width(input int data_w, input int tuser_w);
    return data_w + data_w / 8 + tuser_w + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on contents.
module axis_pkt_fifo_ram
  import axis_pkt_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward packet FIFO: packets appear downstream only once complete,
// and packets that do not fit are dropped whole so the slave side never stalls.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1;
// a master holds tvalid and all payload fields stable until that edge.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int DEPTH_LOG2       = 6,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                          axis_aclk,
  input  logic                          axis_reset,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          drop_pulse,
  output logic [COUNT_WIDTH-1:0]        drop_count
);

  localparam int PW = ptr_width(DEPTH_LOG2);
  localparam int EW = entry_width(AXIS_DATA_WIDTH, AXIS_TUSER_WIDTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(1 << DEPTH_LOG2);

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    used;
  logic             full, in_beat, ram_we, drop_ev, rd_load;
  logic [EW-1:0]    wr_entry, rd_entry, m_entry_q;
  logic             m_tvalid_q, drop_pulse_q;
  logic [COUNT_WIDTH-1:0] drop_count_q;

  assign s_axis_tready = ~axis_reset;
  assign in_beat       = s_axis_tvalid & s_axis_tready;
  assign used          = wr_ptr_q - rd_ptr_q;
  assign full          = (used == DEPTH_P);
  assign wr_entry      = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS:    if (in_beat && full && !s_axis_tlast) state_d = DROP;
      DROP:    if (in_beat && s_axis_tlast) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  // A full hit rewinds wr_ptr to the last commit, erasing the partial packet.
  always_comb begin
    ram_we       = 1'b0;
    drop_ev      = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    if (state_q == PASS && in_beat) begin
      if (!full) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (s_axis_tlast) commit_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        drop_ev  = 1'b1;
        wr_ptr_d = commit_ptr_q;
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      drop_pulse_q <= drop_ev;
      if (drop_ev && (drop_count_q != '1)) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  axis_pkt_fifo_ram #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (axis_aclk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (rd_entry)
  );

  // Only committed entries (below commit_ptr) are ever moved to the output register.
  assign rd_load = (rd_ptr_q != commit_ptr_q) && (!m_tvalid_q || m_axis_tready);

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      rd_ptr_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_entry_q  <= '0;
    end else if (rd_load) begin
      rd_ptr_q   <= rd_ptr_q + 1'b1;
      m_tvalid_q <= 1'b1;
      m_entry_q  <= rd_entry;
    end else if (m_axis_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = m_entry_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign drop_pulse    = drop_pulse_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Randomized bench for axis_pkt_fifo against a queue-based packet model.
module tb_axis_pkt_fifo;

  localparam int DW = 32;
  localparam int UW = 8;
  localparam int KW = DW / 8;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  localparam int CW = 32;
  localparam int EW = DW + KW + UW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          drop_pulse;
  logic [CW-1:0] drop_count;

  axis_pkt_fifo #(
    .AXIS_DATA_WIDTH  (DW),
    .AXIS_TUSER_WIDTH (UW),
    .DEPTH_LOG2       (DL),
    .COUNT_WIDTH      (CW)
  ) dut (
    .axis_aclk     (clk),
    .axis_reset    (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .drop_pulse    (drop_pulse),
    .drop_count    (drop_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q: complete packets' beats waiting in storage; part_q: packet still arriving.
  // Occupancy is exp_q + part_q; the output register holds one more beat outside it.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] part_q[$];
  logic [EW-1:0] mdl_out = '0;
  logic          mdl_valid = 1'b0;
  logic          mdl_dropping = 1'b0;
  logic          mdl_pulse = 1'b0;
  logic [CW-1:0] mdl_drops = '0;
  int            mdl_deliv = 0;
  int            dut_deliv = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      mdl_out = '0;
      mdl_valid = 1'b0;
      mdl_dropping = 1'b0;
      mdl_pulse = 1'b0;
      mdl_drops = '0;
    end else begin
      bit is_full;
      is_full = (exp_q.size() + part_q.size() == DEPTH);
      mdl_pulse = 1'b0;
      if (mdl_valid && m_axis_tready) mdl_deliv++;
      if (exp_q.size() > 0 && (!mdl_valid || m_axis_tready)) begin
        mdl_out = exp_q.pop_front();
        mdl_valid = 1'b1;
      end else if (m_axis_tready) begin
        mdl_valid = 1'b0;
      end
      if (s_axis_tvalid) begin
        if (mdl_dropping) begin
          if (s_axis_tlast) mdl_dropping = 1'b0;
        end else if (is_full) begin
          part_q.delete();
          mdl_pulse = 1'b1;
          if (mdl_drops != '1) mdl_drops = mdl_drops + 1;
          mdl_dropping = !s_axis_tlast;
        end else begin
          part_q.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast});
          if (s_axis_tlast) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
          end
        end
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare on the falling edge ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check_eq("m_tvalid", 64'(m_axis_tvalid), 64'(mdl_valid));
      check_eq("m_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}), 64'(mdl_out));
      check_eq("drop_pulse", 64'(drop_pulse), 64'(mdl_pulse));
      check_eq("drop_count", 64'(drop_count), 64'(mdl_drops));
      check_eq("s_tready", 64'(s_axis_tready), 64'd1);
      if (m_axis_tvalid && m_axis_tready) dut_deliv++;
    end
  end

  // ---------------- master ready driver ----------------
  int rdy_mode = 0;  // 0 low, 1 high, 2 toggle, 3 random
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      2:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(1, 0));
    endcase
  end

  // ---------------- slave driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_beat(input bit last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = DW'($urandom);
    s_axis_tkeep = KW'($urandom);
    s_axis_tuser = UW'($urandom);
    s_axis_tlast = last;
    step();
  endtask

  task automatic send_pkt(input int len, input int max_gap, input int hold_last);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1 && hold_last > 0) idle(hold_last);
      else if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      send_beat(i == len - 1);
    end
    idle(0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  int d0;
  initial begin
    #1;
    check_eq("rst_tready", 64'(s_axis_tready), 64'd0);
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check_eq("rst_count", 64'(drop_count), 64'd0);
    do_reset();

    // Single 4-beat packet streams out straight after commit.
    rdy_mode = 1;
    d0 = dut_deliv;
    send_pkt(4, 0, 0);
    idle(10);
    check_eq("s1_beats", 64'(dut_deliv - d0), 64'd4);
    check_eq("s1_drops", 64'(drop_count), 64'd0);

    // tlast withheld for 20 cycles: nothing may appear before commit.
    d0 = dut_deliv;
    send_pkt(3, 0, 20);
    idle(10);
    check_eq("s2_beats", 64'(dut_deliv - d0), 64'd3);

    // Stalled master: storage plus the output register take 17 one-beat packets.
    do_reset();
    rdy_mode = 0;
    d0 = dut_deliv;
    for (int i = 0; i < 18; i++) send_beat(1'b1);
    idle(3);
    check_eq("s3_drops", 64'(drop_count), 64'd1);
    rdy_mode = 1;
    idle(25);
    check_eq("s3_beats", 64'(dut_deliv - d0), 64'd17);

    // Oversize packet is dropped whole; the next packet is intact.
    do_reset();
    d0 = dut_deliv;
    send_pkt(20, 0, 0);
    idle(5);
    check_eq("s4_drops", 64'(drop_count), 64'd1);
    check_eq("s4_none", 64'(dut_deliv - d0), 64'd0);
    send_pkt(2, 0, 0);
    idle(6);
    check_eq("s4_beats", 64'(dut_deliv - d0), 64'd2);

    // Back-to-back 1-beat packets with ready toggling.
    do_reset();
    rdy_mode = 2;
    d0 = dut_deliv;
    for (int i = 0; i < 20; i++) send_beat(1'b1);
    idle(50);
    check_eq("s5_beats", 64'(dut_deliv - d0), 64'd20);
    check_eq("s5_drops", 64'(drop_count), 64'd0);

    // Reset mid-packet with a beat held at the output and 5 beats partial.
    rdy_mode = 0;
    idle(2);
    send_pkt(2, 0, 0);
    for (int i = 0; i < 5; i++) send_beat(1'b0);
    idle(1);
    check_eq("s6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("s6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("s6_rst_tready", 64'(s_axis_tready), 64'd0);
    idle(2);
    rst = 1'b0;
    step();
    rdy_mode = 1;
    d0 = dut_deliv;
    send_pkt(2, 0, 0);
    idle(8);
    check_eq("s6_beats", 64'(dut_deliv - d0), 64'd2);

    // Random traffic: lengths 1..20, random gaps, random master ready.
    rdy_mode = 3;
    for (int p = 0; p < 60; p++) send_pkt(int'($urandom_range(20, 1)), 2, 0);
    rdy_mode = 1;
    idle(60);
    check_eq("rand_beats", 64'(dut_deliv), 64'(mdl_deliv));
    check_eq("rand_drained", 64'(m_axis_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
